// File: rtl/sub32_pipe_112.sv
// sub32_pipe_112: two-stage pipelined subtractor computing S = A + ~B + c0.
// Stage 1 resolves the low half and registers its carry (c16).
// Stage 2 resolves the high half using that registered carry.
// Both sides use a valid/ready handshake, so the pipe can absorb backpressure.
// Optional macro SUB32_FLAGS_EN adds registered ZERO/OV/LTU/LTS flag outputs.
// Operands and result are indexed [WIDTH:1]; WIDTH must be even.

module sub32_pipe_112 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH:1]   A,
  input  logic [WIDTH:1]   B,
  input  logic             c0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:1]   S,
  output logic             C32,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SUB32_FLAGS_EN
  ,
  output logic             ZERO,
  output logic             OV,
  output logic             LTU,
  output logic             LTS
`endif
);

  localparam int H = WIDTH / 2;

  // The datapath is split into two equal halves, so an odd width cannot be built.
  if ((WIDTH % 2) != 0) begin : gOddWidth
    $error("sub32_pipe_112: WIDTH must be even");
  end

  // Stage 1 registers: low-half result, its carry, and the prepared high-half operands.
  logic [H-1:0]   lo_q,      lo_d;
  logic           c16_q,     c16_d;
  logic [H-1:0]   aHi_q,     aHi_d;
  logic [H-1:0]   bHiN_q,    bHiN_d;
  logic           s1Valid_q, s1Valid_d;

  // Stage 2 registers: full difference, carry out and output valid.
  logic [WIDTH-1:0] s_q,        s_d;
  logic             c32_q,      c32_d;
  logic             outValid_q, outValid_d;

`ifdef SUB32_FLAGS_EN
  logic zero_q, zero_d;
  logic ov_q,   ov_d;
  logic ltu_q,  ltu_d;
  logic lts_q,  lts_d;
`endif

  // Handshake terms shared by both stages.
  logic accept;
  logic advance;
  logic [H:0] loSum;
  logic [H:0] hiSum;
  logic [WIDTH-1:0] fullDiff;

  // Stage 1 can take a new operand whenever it is empty or is about to drain.
  assign in_ready = ~s1Valid_q | ~outValid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign advance  = s1Valid_q & (~outValid_q | out_ready);

  // Low-half sum, extended by one bit so its carry-out falls out of the MSB.
  assign loSum = {1'b0, A[H:1]} + {1'b0, ~B[H:1]} + {{H{1'b0}}, c0};

  // High-half sum, consuming the carry registered by stage 1.
  assign hiSum = {1'b0, aHi_q} + {1'b0, bHiN_q} + {{H{1'b0}}, c16_q};

  assign fullDiff = {hiSum[H-1:0], lo_q};

  // Stage 1 next state: load on accept, otherwise empty out when stage 2 takes the entry.
  always_comb begin
    lo_d      = lo_q;
    c16_d     = c16_q;
    aHi_d     = aHi_q;
    bHiN_d    = bHiN_q;
    s1Valid_d = s1Valid_q;
    if (accept) begin
      lo_d      = loSum[H-1:0];
      c16_d     = loSum[H];
      aHi_d     = A[WIDTH:H+1];
      bHiN_d    = ~B[WIDTH:H+1];
      s1Valid_d = 1'b1;
    end else if (advance) begin
      s1Valid_d = 1'b0;
    end
  end

  // Stage 2 next state: capture on advance, drop valid only when consumed with nothing behind it.
  always_comb begin
    s_d        = s_q;
    c32_d      = c32_q;
    outValid_d = outValid_q;
    if (advance) begin
      s_d        = fullDiff;
      c32_d      = hiSum[H];
      outValid_d = 1'b1;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

`ifdef SUB32_FLAGS_EN
  // Flags are computed from the stage 2 result and captured together with S.
  logic aTop;
  logic bTop;
  logic sTop;
  logic ovNow;

  assign aTop  = aHi_q[H-1];
  assign bTop  = ~bHiN_q[H-1];
  assign sTop  = hiSum[H-1];
  assign ovNow = (aTop ^ bTop) & (sTop ^ aTop);

  // Flag next state follows the same advance condition as the result.
  always_comb begin
    zero_d = zero_q;
    ov_d   = ov_q;
    ltu_d  = ltu_q;
    lts_d  = lts_q;
    if (advance) begin
      zero_d = (fullDiff == '0);
      ov_d   = ovNow;
      ltu_d  = ~hiSum[H];
      lts_d  = sTop ^ ovNow;
    end
  end

  // Flag registers; cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ov_q   <= 1'b0;
      ltu_q  <= 1'b0;
      lts_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ov_q   <= ov_d;
      ltu_q  <= ltu_d;
      lts_q  <= lts_d;
    end
  end

  assign ZERO = zero_q;
  assign OV   = ov_q;
  assign LTU  = ltu_q;
  assign LTS  = lts_q;
`endif

  // Stage 1 registers; reset discards any in-flight operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q      <= '0;
      c16_q     <= 1'b0;
      aHi_q     <= '0;
      bHiN_q    <= '0;
      s1Valid_q <= 1'b0;
    end else begin
      lo_q      <= lo_d;
      c16_q     <= c16_d;
      aHi_q     <= aHi_d;
      bHiN_q    <= bHiN_d;
      s1Valid_q <= s1Valid_d;
    end
  end

  // Stage 2 registers; reset clears the visible result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '0;
      c32_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      c32_q      <= c32_d;
      outValid_q <= outValid_d;
    end
  end

  assign S         = s_q;
  assign C32       = c32_q;
  assign out_valid = outValid_q;

endmodule
